// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared configuration for the scoreboard destination-table slice.
//   NR_SB_ENTRIES : default number of scoreboard entries (power of two, >= 2)
//   RD_W          : GPR index width
//   sb_idx_t      : scoreboard entry index type
//   sb_rd_entry_t : per-entry state {valid, done, we, rd}
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int NR_SB_ENTRIES = 8;
    localparam int RD_W          = 5;

    typedef logic [$clog2(NR_SB_ENTRIES)-1:0] sb_idx_t;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic            we;
        logic [RD_W-1:0] rd;
    } sb_rd_entry_t;

endpackage

// File: rtl/sb_ptr_ctr.sv
// -----------------------------------------------------------------------------
// sb_ptr_ctr
// Wrapping pointer register used for the scoreboard head and tail.
// The pointer wraps naturally modulo 2**W, so the entry count must be a
// power of two.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (pointer -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : advance pointer by one
//   ptr_o  : current pointer value
// -----------------------------------------------------------------------------
module sb_ptr_ctr #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] ptr_q;
    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sb_rd_tracker.sv
// -----------------------------------------------------------------------------
// sb_rd_tracker
// Writer side of the scoreboard destination table. Entries are allocated in
// program order at issue (tail), marked done on writeback and retired in
// order at commit (head). Publishes per-entry rd / still-issued vectors for
// the issue-stage RAW hazard checkers.
//
// Optional feature macro: SB_WB_BYPASS_EN
//   defined   : still_issued_o[wb_idx_i] is forced low combinationally in the
//               writeback cycle (saves one stall cycle for dependents).
//   undefined : still_issued_o is purely registered.
//
// Ports:
//   clk_i, rst_i          : clock / asynchronous active-high reset
//   flush_i               : discard all entries (highest priority)
//   issue_valid_i/ready_o : allocation handshake
//   issue_we_i, issue_rd_i: destination info of the issuing instruction
//   issue_idx_o           : slot allocated on accept (== issue_pointer_o)
//   wb_valid_i, wb_idx_i  : functional-unit writeback
//   commit_valid_o/idx_o/rd_o/we_o : head entry view for the commit stage
//   commit_ack_i          : commit stage retires the head
//   rd_o                  : flattened per-entry rd, entry i at [i*5 +: 5]
//   still_issued_o        : valid & we & !done per entry
//   issue_pointer_o       : tail pointer
//   empty_o               : no valid entries
// -----------------------------------------------------------------------------
module sb_rd_tracker
    import config_pkg::*;
#(
    parameter int NR_ENTRIES = config_pkg::NR_SB_ENTRIES,
    parameter int IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic                       issue_we_i,
    input  logic [4:0]                 issue_rd_i,
    output logic [IDX_W-1:0]           issue_idx_o,
    input  logic                       wb_valid_i,
    input  logic [IDX_W-1:0]           wb_idx_i,
    output logic                       commit_valid_o,
    output logic [IDX_W-1:0]           commit_idx_o,
    output logic [4:0]                 commit_rd_o,
    output logic                       commit_we_o,
    input  logic                       commit_ack_i,
    output logic [NR_ENTRIES*5-1:0]    rd_o,
    output logic [NR_ENTRIES-1:0]      still_issued_o,
    output logic [IDX_W-1:0]           issue_pointer_o,
    output logic                       empty_o
);

    sb_rd_entry_t     entry_q [NR_ENTRIES];
    sb_rd_entry_t     entry_d [NR_ENTRIES];
    logic [IDX_W:0]   count_q;
    logic [IDX_W:0]   count_d;
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;

    logic         issue_accept;
    logic         commit_fire;
    sb_rd_entry_t head_entry;

    // Readiness looks only at registered count, so a slot freed by a commit
    // in this cycle cannot be reallocated until the next one.
    assign issue_ready_o = (count_q != (IDX_W + 1)'(NR_ENTRIES));
    assign issue_accept  = issue_valid_i & issue_ready_o & ~flush_i;

    assign head_entry     = entry_q[head_q];
    assign commit_valid_o = head_entry.valid & head_entry.done;
    assign commit_fire    = commit_valid_o & commit_ack_i & ~flush_i;

    sb_ptr_ctr #(.W(IDX_W)) u_head (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (commit_fire),
        .ptr_o (head_q)
    );

    sb_ptr_ctr #(.W(IDX_W)) u_tail (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (flush_i),
        .inc_i (issue_accept),
        .ptr_o (tail_q)
    );

    // Entry next-state. Issue and commit never target the same slot in one
    // cycle (that would need a full table, which blocks issue). Commit is
    // applied last so a redundant writeback to the retiring head cannot
    // resurrect its done bit.
    always_comb begin
        for (int i = 0; i < NR_ENTRIES; i++) begin
            entry_d[i] = entry_q[i];
            if (flush_i) begin
                entry_d[i] = '0;
            end else begin
                if (wb_valid_i && (wb_idx_i == IDX_W'(i)) && entry_q[i].valid) begin
                    entry_d[i].done = 1'b1;
                end
                if (issue_accept && (tail_q == IDX_W'(i))) begin
                    entry_d[i].valid = 1'b1;
                    entry_d[i].done  = 1'b0;
                    entry_d[i].we    = issue_we_i;
                    entry_d[i].rd    = issue_we_i ? issue_rd_i : 5'd0;
                end
                if (commit_fire && (head_q == IDX_W'(i))) begin
                    // rd is left in place: rd_o is the raw stored value.
                    entry_d[i].valid = 1'b0;
                    entry_d[i].done  = 1'b0;
                    entry_d[i].we    = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (issue_accept && !commit_fire) begin
            count_d = count_q + (IDX_W + 1)'(1);
        end else if (!issue_accept && commit_fire) begin
            count_d = count_q - (IDX_W + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    assign issue_idx_o     = tail_q;
    assign issue_pointer_o = tail_q;
    assign empty_o         = (count_q == '0);
    assign commit_idx_o    = head_q;
    assign commit_we_o     = head_entry.we;
    assign commit_rd_o     = head_entry.we ? head_entry.rd : 5'd0;

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry_out
        assign rd_o[gi*5 +: 5] = entry_q[gi].rd;
`ifdef SB_WB_BYPASS_EN
        // Writeback in flight this cycle already resolves the hazard.
        assign still_issued_o[gi] = entry_q[gi].valid & entry_q[gi].we & ~entry_q[gi].done
                                  & ~(wb_valid_i & (wb_idx_i == IDX_W'(gi)));
`else
        assign still_issued_o[gi] = entry_q[gi].valid & entry_q[gi].we & ~entry_q[gi].done;
`endif
    end

endmodule

// File: tb/tb_sb_rd_tracker.sv
module tb_sb_rd_tracker;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         issue_valid;
    logic         issue_ready;
    logic         issue_we;
    logic [4:0]   issue_rd;
    logic [2:0]   issue_idx;
    logic         wb_valid;
    logic [2:0]   wb_idx;
    logic         commit_valid;
    logic [2:0]   commit_idx;
    logic [4:0]   commit_rd;
    logic         commit_we;
    logic         commit_ack;
    logic [N*5-1:0] rd_vec;
    logic [N-1:0] still_issued;
    logic [2:0]   issue_ptr;
    logic         empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sb_rd_tracker #(.NR_ENTRIES(N)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .flush_i         (flush),
        .issue_valid_i   (issue_valid),
        .issue_ready_o   (issue_ready),
        .issue_we_i      (issue_we),
        .issue_rd_i      (issue_rd),
        .issue_idx_o     (issue_idx),
        .wb_valid_i      (wb_valid),
        .wb_idx_i        (wb_idx),
        .commit_valid_o  (commit_valid),
        .commit_idx_o    (commit_idx),
        .commit_rd_o     (commit_rd),
        .commit_we_o     (commit_we),
        .commit_ack_i    (commit_ack),
        .rd_o            (rd_vec),
        .still_issued_o  (still_issued),
        .issue_pointer_o (issue_ptr),
        .empty_o         (empty)
    );

    typedef struct {
        logic       fl;
        logic       iv;
        logic       we;
        logic [4:0] rd;
        logic       wv;
        logic [2:0] wi;
        logic       ack;
        logic       e_rdy;
        logic [2:0] e_ptr;
        logic       e_emp;
        logic       e_cv;
        logic [2:0] e_cidx;
        logic [4:0] e_crd;
        logic [7:0] e_si;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush = 0; issue_valid = 0; issue_we = 0; issue_rd = 0;
        wb_valid = 0; wb_idx = 0; commit_ack = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 0;
    endtask

    // Clock the currently driven inputs in, then return to idle inputs.
    task automatic step();
        @(posedge clk);
        #1 idle();
    endtask

    function automatic logic [4:0] rd_of(input int i);
        return rd_vec[i*5 +: 5];
    endfunction

    initial begin
        logic exp_bypass;

        // fl iv we rd  wv wi ack | rdy ptr emp cv cidx crd si
        vecs[0] = '{0,1,1,5'd5, 0,3'd0,0, 1,3'd1,0,0,3'd0,5'd5,8'b0000_0001};
        vecs[1] = '{0,1,0,5'd7, 0,3'd0,0, 1,3'd2,0,0,3'd0,5'd5,8'b0000_0001};
        vecs[2] = '{0,1,1,5'd9, 0,3'd0,0, 1,3'd3,0,0,3'd0,5'd5,8'b0000_0101};
        vecs[3] = '{0,0,0,5'd0, 1,3'd0,0, 1,3'd3,0,1,3'd0,5'd5,8'b0000_0100};
        vecs[4] = '{0,0,0,5'd0, 1,3'd1,1, 1,3'd3,0,1,3'd1,5'd0,8'b0000_0100};
        vecs[5] = '{0,0,0,5'd0, 0,3'd0,1, 1,3'd3,0,0,3'd2,5'd9,8'b0000_0100};
        vecs[6] = '{0,0,0,5'd0, 1,3'd5,0, 1,3'd3,0,0,3'd2,5'd9,8'b0000_0100};
        vecs[7] = '{0,0,0,5'd0, 1,3'd2,1, 1,3'd3,0,1,3'd2,5'd9,8'b0000_0000};
        vecs[8] = '{0,0,0,5'd0, 0,3'd0,1, 1,3'd3,1,0,3'd3,5'd0,8'b0000_0000};

        do_reset();

        // Reset state
        chk("rst_ready", 32'(issue_ready), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_cvalid", 32'(commit_valid), 32'd0);
        chk("rst_si", 32'(still_issued), 32'd0);
        chk("rst_rd", 32'(rd_vec), 32'd0);
        chk("rst_ptr", 32'(issue_ptr), 32'd0);
        chk("rst_idx", 32'(issue_idx), 32'd0);
        chk("rst_cidx", 32'(commit_idx), 32'd0);
        chk("rst_crd", 32'(commit_rd), 32'd0);
        chk("rst_cwe", 32'(commit_we), 32'd0);

        // Table-driven vectors
        for (int v = 0; v < 9; v++) begin
            flush = vecs[v].fl; issue_valid = vecs[v].iv; issue_we = vecs[v].we;
            issue_rd = vecs[v].rd; wb_valid = vecs[v].wv; wb_idx = vecs[v].wi;
            commit_ack = vecs[v].ack;
            step();
            chk($sformatf("v%0d_ready", v), 32'(issue_ready), 32'(vecs[v].e_rdy));
            chk($sformatf("v%0d_ptr", v), 32'(issue_ptr), 32'(vecs[v].e_ptr));
            chk($sformatf("v%0d_empty", v), 32'(empty), 32'(vecs[v].e_emp));
            chk($sformatf("v%0d_cvalid", v), 32'(commit_valid), 32'(vecs[v].e_cv));
            chk($sformatf("v%0d_cidx", v), 32'(commit_idx), 32'(vecs[v].e_cidx));
            chk($sformatf("v%0d_crd", v), 32'(commit_rd), 32'(vecs[v].e_crd));
            chk($sformatf("v%0d_si", v), 32'(still_issued), 32'(vecs[v].e_si));
            $display("vec %0d: ptr=%0d cidx=%0d cv=%0b si=%08b", v, issue_ptr, commit_idx, commit_valid, still_issued);
        end
        chk("tbl_rd0", 32'(rd_of(0)), 32'd5);
        chk("tbl_rd1", 32'(rd_of(1)), 32'd0);

        // First issue latency and index
        do_reset();
        issue_valid = 1; issue_we = 1; issue_rd = 5'd5;
        #1 chk("first_idx", 32'(issue_idx), 32'd0);
        step();
        chk("first_si", 32'(still_issued), 32'b0000_0001);
        chk("first_rd0", 32'(rd_of(0)), 32'd5);
        chk("first_ptr", 32'(issue_ptr), 32'd1);
        $display("first issue: idx0 rd=%0d ptr=%0d", rd_of(0), issue_ptr);

        // Fill to full, then a rejected 9th issue
        do_reset();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("fill_ready%0d", i), 32'(issue_ready), 32'd1);
            issue_valid = 1; issue_we = 1; issue_rd = 5'(i + 5);
            step();
        end
        chk("full_ready", 32'(issue_ready), 32'd0);
        chk("full_ptr", 32'(issue_ptr), 32'd0);
        chk("full_si", 32'(still_issued), 32'hFF);
        issue_valid = 1; issue_we = 1; issue_rd = 5'd31;
        step();
        chk("ninth_ptr", 32'(issue_ptr), 32'd0);
        chk("ninth_rd0", 32'(rd_of(0)), 32'd5);
        chk("ninth_ready", 32'(issue_ready), 32'd0);
        $display("fill: ready=%0b ptr=%0d si=%02h", issue_ready, issue_ptr, still_issued);

        // Writeback then commit from full
        wb_valid = 1; wb_idx = 3'd0;
        step();
        chk("wb_cvalid", 32'(commit_valid), 32'd1);
        chk("wb_crd", 32'(commit_rd), 32'd5);
        chk("wb_cwe", 32'(commit_we), 32'd1);
        chk("wb_ready_still_full", 32'(issue_ready), 32'd0);
        commit_ack = 1;
        step();
        chk("ack_cidx", 32'(commit_idx), 32'd1);
        chk("ack_ready", 32'(issue_ready), 32'd1);
        chk("ack_cvalid", 32'(commit_valid), 32'd0);
        $display("commit: head=%0d ready=%0b", commit_idx, issue_ready);

        // Wrap around with 10 issue/writeback/commit rounds
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [2:0] slot;
            slot = issue_ptr;
            issue_valid = 1; issue_we = 1; issue_rd = 5'(10 + i);
            step();
            wb_valid = 1; wb_idx = slot;
            step();
            commit_ack = 1;
            step();
        end
        chk("wrap_ptr", 32'(issue_ptr), 32'd2);
        chk("wrap_head", 32'(commit_idx), 32'd2);
        chk("wrap_empty", 32'(empty), 32'd1);
        chk("wrap_rd1", 32'(rd_of(1)), 32'd19);
        $display("wrap: tail=%0d head=%0d rd1=%0d", issue_ptr, commit_idx, rd_of(1));

        // Flush with everything else asserted at count=5
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1; issue_we = 1; issue_rd = 5'(i + 1);
            step();
        end
        wb_valid = 1; wb_idx = 3'd0;
        step();
        chk("pre_flush_cvalid", 32'(commit_valid), 32'd1);
        flush = 1; issue_valid = 1; issue_we = 1; issue_rd = 5'd20;
        wb_valid = 1; wb_idx = 3'd1; commit_ack = 1;
        step();
        chk("flush_si", 32'(still_issued), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_ptr", 32'(issue_ptr), 32'd0);
        chk("flush_cvalid", 32'(commit_valid), 32'd0);
        chk("flush_cidx", 32'(commit_idx), 32'd0);
        chk("flush_rd", 32'(rd_vec), 32'd0);
        $display("flush: si=%02h empty=%0b ptr=%0d", still_issued, empty, issue_ptr);

        // Writeback bypass on still_issued
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1; issue_we = 1; issue_rd = 5'(i + 1);
            step();
        end
        chk("byp_pre_si3", 32'(still_issued[3]), 32'd1);
`ifdef SB_WB_BYPASS_EN
        exp_bypass = 1'b0;
`else
        exp_bypass = 1'b1;
`endif
        wb_valid = 1; wb_idx = 3'd3;
        #1 chk("byp_same_cycle_si3", 32'(still_issued[3]), 32'(exp_bypass));
        chk("byp_same_cycle_cvalid", 32'(commit_valid), 32'd0);
        step();
        chk("byp_next_si3", 32'(still_issued[3]), 32'd0);
        chk("byp_next_si", 32'(still_issued), 32'b0000_0111);
        $display("bypass: si=%04b", still_issued[3:0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sb_rd_tracker.md
Name: sb_rd_tracker

Overview:
- Writer side of the scoreboard destination table.
- Allocates scoreboard entries in program order at issue and records each entry's destination GPR.
- Clears an entry's in-flight flag on writeback and retires entries in order at commit.
- Drives the per-entry rd / still-issued / issue-pointer vectors consumed by the RAW hazard checkers in the issue stage.

Parameters:
- NR_ENTRIES, default config_pkg::NR_SB_ENTRIES (8): number of scoreboard entries; power of two, >= 2.
- IDX_W, default $clog2(NR_ENTRIES): entry index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  discard all entries (mispredict/exception).
- issue_valid_i  in  1  request to allocate one entry.
- issue_ready_o  out  1  entry available (not full).
- issue_we_i  in  1  instruction writes a GPR.
- issue_rd_i  in  5  destination register.
- issue_idx_o  out  IDX_W  index allocated on an accepted issue; equals issue_pointer_o.
- wb_valid_i  in  1  functional-unit writeback.
- wb_idx_i  in  IDX_W  entry being written back.
- commit_valid_o  out  1  head entry valid and done.
- commit_idx_o  out  IDX_W  head index.
- commit_rd_o  out  5  head rd (0 when we=0).
- commit_we_o  out  1  head writes a GPR.
- commit_ack_i  in  1  commit stage retires head.
- rd_o  out  NR_ENTRIES x 5  per-entry stored rd.
- still_issued_o  out  NR_ENTRIES  valid & we & !done per entry.
- issue_pointer_o  out  IDX_W  tail: next slot to allocate.
- empty_o  out  1  no valid entries.

Behaviour:
- Entry state: valid, done, we, rd[4:0]. Registers: head, tail (IDX_W, wrap mod NR_ENTRIES), count (IDX_W+1).
- Reset: all entry fields 0, head=tail=count=0.
  - Outputs after reset: issue_ready_o=1, empty_o=1, commit_valid_o=0, still_issued_o=0, rd_o all 0, issue_pointer_o=0, issue_idx_o=0, commit_idx_o=0, commit_rd_o=0, commit_we_o=0.
- issue_ready_o = (count != NR_ENTRIES); depends on registered state only.
  - No same-cycle reuse of a slot freed by commit.
- Accepted issue (issue_valid_i & issue_ready_o):
  - Entry[tail] <= {valid=1, done=0, we=issue_we_i, rd=issue_we_i ? issue_rd_i : 0}.
  - tail <= tail+1, wrapping.
- issue_rd_i=0 with we=1: stored as is. Consumers mask x0.
- Writeback:
  - Sets done on entry[wb_idx_i] next cycle.
  - Ignored if that entry is not valid.
  - A repeated writeback to a done entry is harmless.
- commit_valid_o = entry[head].valid & entry[head].done (registered state).
- Commit (commit_valid_o & commit_ack_i): clears entry[head].valid/done/we, then head <= head+1.
  - commit_ack_i without commit_valid_o: ignored.
- count next = count + issue_accept - commit_fire; simultaneous issue and commit leave count unchanged.
- Writeback on the cycle an entry is allocated: impossible by protocol. Writeback to an invalid index is ignored.
- flush_i: next cycle all valid/done/we = 0, rd = 0, head=tail=count=0.
  - Takes priority over issue, writeback and commit in the same cycle.
  - The issue is not accepted; the issuer re-presents it.
- rd_o is the raw stored rd, independent of valid.
- All outputs are combinational from registers; no input-to-output paths except under the macro below.
- Latency: issue to visible still_issued_o is 1 cycle; writeback to cleared still_issued_o is 1 cycle; writeback to commit_valid_o is 1 cycle.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- When defined: still_issued_o[wb_idx_i] is forced to 0 combinationally in the writeback cycle, removing one stall cycle for a dependent instruction. commit_valid_o is unchanged (still registered).
- When undefined: still_issued_o is purely registered.

Decomposition:
- config_pkg: NR_SB_ENTRIES; typedef sb_idx_t (logic [$clog2(NR_SB_ENTRIES)-1:0]); typedef sb_rd_entry_t struct {valid, done, we, rd[4:0]}.
- One natural sub-module: sb_ptr_ctr, a wrapping IDX_W pointer with increment and clear, instantiated for head and tail.

Test Plan (NR_ENTRIES=8):
- Reset then issue rd=5 we=1 → issue_idx_o=0; next cycle still_issued_o=8'b0000_0001, rd_o[0]=5, issue_pointer_o=1.
- Fill 8 issues with no commit → issue_ready_o=0 after the 8th, count=8. A 9th issue_valid_i is not accepted and tail stays 0.
- Writeback idx 0 then commit_ack_i → commit_valid_o=1 with commit_rd_o=5 one cycle after writeback. After the ack, head=1 and issue_ready_o=1 again.
- Wrap: 10 issue/wb/commit pairs → tail=2, head=2, empty_o=1; entry 1 rd equals the 10th issue's rd.
- flush_i together with issue_valid_i, wb_valid_i and commit_ack_i at count=5 → next cycle still_issued_o=0, empty_o=1, issue_pointer_o=0, no commit observed.
- SB_WB_BYPASS_EN: entry 3 in flight, wb_idx_i=3 → still_issued_o[3]=0 in the same cycle. Without the macro it clears the cycle after.
